// File: rtl/ex_mem_reg_if.sv
// EX/MEM pipeline register bus.
// Groups the EX-side inputs (stall/flush, ALU payload, controls) and the MEM-side
// registered outputs (payload, qualified controls, exception/EPC/trap counter).
// master: EX stage / hazard unit driving the register; slave: the register itself.
interface ex_mem_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [DATA_W-1:0] pc_i;
  logic [DATA_W-1:0] alu_result_i;
  logic              zero_i;
  logic              overflow_i;
  logic              cout_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [4:0]        write_reg_i;
  logic              reg_write_i;
  logic              mem_read_i;
  logic              mem_write_i;
  logic              mem_to_reg_i;
  logic              branch_i;
  logic              ovf_trap_i;

  logic              valid_o;
  logic [DATA_W-1:0] pc_o;
  logic [DATA_W-1:0] alu_result_o;
  logic [DATA_W-1:0] rt_data_o;
  logic              zero_o;
  logic              cout_o;
  logic [4:0]        write_reg_o;
  logic              reg_write_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic              mem_to_reg_o;
  logic              branch_taken_o;
  logic              exc_o;
  logic [DATA_W-1:0] epc_o;
  logic [CNT_W-1:0]  ovf_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, pc_i, alu_result_i, zero_i, overflow_i, cout_i,
           rt_data_i, write_reg_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i,
           branch_i, ovf_trap_i,
    input  valid_o, pc_o, alu_result_o, rt_data_o, zero_o, cout_o, write_reg_o,
           reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_taken_o, exc_o,
           epc_o, ovf_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, pc_i, alu_result_i, zero_i, overflow_i, cout_i,
           rt_data_i, write_reg_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i,
           branch_i, ovf_trap_i,
    output valid_o, pc_o, alu_result_o, rt_data_o, zero_o, cout_o, write_reg_o,
           reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_taken_o, exc_o,
           epc_o, ovf_cnt_o
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Captures the ALU result/flags and the MEM/WB controls of the EX instruction with
// one cycle of latency. Priority per edge: flush > stall > load. Signed overflow on
// a trapping instruction suppresses side effects, pulses exc_o for one cycle,
// records the EPC and bumps a saturating trap counter.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous reset, active low
//   bus    - ex_mem_reg_if.slave: EX-side inputs and MEM-side registered outputs
module ex_mem_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8
) (
  input logic         clk_i,
  input logic         rst_i,
  ex_mem_reg_if.slave bus
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic              zero_q, zero_d;
  logic              cout_q, cout_d;
  logic [4:0]        wr_q, wr_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic              m2r_q, m2r_d;
  logic              bt_q, bt_d;
  logic              exc_q, exc_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic load;
  logic trap;

  assign load = ~bus.flush_i & ~bus.stall_i;
  assign trap = load & bus.valid_i & bus.ovf_trap_i & bus.overflow_i;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    rt_d    = rt_q;
    zero_d  = zero_q;
    cout_d  = cout_q;
    wr_d    = wr_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    m2r_d   = m2r_q;
    bt_d    = bt_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    // The pulse is only ever set by a trap load, so stall and flush both clear it.
    exc_d   = 1'b0;

    if (bus.flush_i) begin
      // Bubble: kill validity and all side-effect controls; data fields just hold.
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      m2r_d   = 1'b0;
      bt_d    = 1'b0;
    end else if (load) begin
      valid_d = bus.valid_i;
      pc_d    = bus.pc_i;
      alu_d   = bus.alu_result_i;
      rt_d    = bus.rt_data_i;
      zero_d  = bus.zero_i;
      cout_d  = bus.cout_i;
      wr_d    = bus.write_reg_i;
      // $zero is never a write-back target.
      rw_d    = bus.valid_i & bus.reg_write_i & (bus.write_reg_i != 5'd0) & ~trap;
      mr_d    = bus.valid_i & bus.mem_read_i & ~trap;
      mw_d    = bus.valid_i & bus.mem_write_i & ~trap;
      m2r_d   = bus.valid_i & bus.mem_to_reg_i;
      bt_d    = bus.valid_i & bus.branch_i & bus.zero_i & ~trap;
      exc_d   = trap;
      if (trap) begin
        epc_d = bus.pc_i;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      alu_q   <= '0;
      rt_q    <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      wr_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      bt_q    <= 1'b0;
      exc_q   <= 1'b0;
      epc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      rt_q    <= rt_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      m2r_q   <= m2r_d;
      bt_q    <= bt_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.valid_o        = valid_q;
  assign bus.pc_o           = pc_q;
  assign bus.alu_result_o   = alu_q;
  assign bus.rt_data_o      = rt_q;
  assign bus.zero_o         = zero_q;
  assign bus.cout_o         = cout_q;
  assign bus.write_reg_o    = wr_q;
  assign bus.reg_write_o    = rw_q;
  assign bus.mem_read_o     = mr_q;
  assign bus.mem_write_o    = mw_q;
  assign bus.mem_to_reg_o   = m2r_q;
  assign bus.branch_taken_o = bt_q;
  assign bus.exc_o          = exc_q;
  assign bus.epc_o          = epc_q;
  assign bus.ovf_cnt_o      = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios followed by random traffic, checked
// against an instruction-level reference model. Two instances share stimulus:
// one with the default 8-bit trap counter, one with a 2-bit counter for saturation.
module tb_ex_mem_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        stall, flush, valid, zero, ovf, cout, rw, mr, mw, m2r, br, trap_en;
  logic [31:0] pc, alu, rt;
  logic [4:0]  wr;

  int total = 0;
  int bad   = 0;

  // Reference state: what MEM should hold after each edge.
  logic        e_valid, e_zero, e_cout, e_rw, e_mr, e_mw, e_m2r, e_bt, e_exc;
  logic [31:0] e_pc, e_alu, e_rt, e_epc;
  logic [4:0]  e_wr;
  int          e_traps;

  ex_mem_reg_if #(.DATA_W(32), .CNT_W(8)) bus8 ();
  ex_mem_reg_if #(.DATA_W(32), .CNT_W(2)) bus2 ();

  ex_mem_reg #(.DATA_W(32), .CNT_W(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8));
  ex_mem_reg #(.DATA_W(32), .CNT_W(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  assign bus8.stall_i = stall;      assign bus2.stall_i = stall;
  assign bus8.flush_i = flush;      assign bus2.flush_i = flush;
  assign bus8.valid_i = valid;      assign bus2.valid_i = valid;
  assign bus8.pc_i = pc;            assign bus2.pc_i = pc;
  assign bus8.alu_result_i = alu;   assign bus2.alu_result_i = alu;
  assign bus8.zero_i = zero;        assign bus2.zero_i = zero;
  assign bus8.overflow_i = ovf;     assign bus2.overflow_i = ovf;
  assign bus8.cout_i = cout;        assign bus2.cout_i = cout;
  assign bus8.rt_data_i = rt;       assign bus2.rt_data_i = rt;
  assign bus8.write_reg_i = wr;     assign bus2.write_reg_i = wr;
  assign bus8.reg_write_i = rw;     assign bus2.reg_write_i = rw;
  assign bus8.mem_read_i = mr;      assign bus2.mem_read_i = mr;
  assign bus8.mem_write_i = mw;     assign bus2.mem_write_i = mw;
  assign bus8.mem_to_reg_i = m2r;   assign bus2.mem_to_reg_i = m2r;
  assign bus8.branch_i = br;        assign bus2.branch_i = br;
  assign bus8.ovf_trap_i = trap_en; assign bus2.ovf_trap_i = trap_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  task automatic model_reset();
    {e_valid, e_zero, e_cout, e_rw, e_mr, e_mw, e_m2r, e_bt, e_exc} = '0;
    e_pc = '0; e_alu = '0; e_rt = '0; e_epc = '0; e_wr = '0;
    e_traps = 0;
  endtask

  // Effect of one edge on the instruction in MEM, from the current inputs.
  task automatic model_edge();
    bit is_trap;
    is_trap = !flush && !stall && valid && trap_en && ovf;
    if (flush) begin
      {e_valid, e_rw, e_mr, e_mw, e_m2r, e_bt, e_exc} = '0;
    end else if (stall) begin
      e_exc = 1'b0;
    end else begin
      e_valid = valid;
      e_pc = pc; e_alu = alu; e_rt = rt; e_zero = zero; e_cout = cout; e_wr = wr;
      e_rw  = valid && rw && wr != 0 && !is_trap;
      e_mr  = valid && mr && !is_trap;
      e_mw  = valid && mw && !is_trap;
      e_m2r = valid && m2r;
      e_bt  = valid && br && zero && !is_trap;
      e_exc = is_trap;
      if (is_trap) begin
        e_epc = pc;
        e_traps++;
      end
    end
  endtask

  task automatic check_all();
    check("valid", 32'(bus8.valid_o), 32'(e_valid));
    check("reg_write", 32'(bus8.reg_write_o), 32'(e_rw));
    check("mem_read", 32'(bus8.mem_read_o), 32'(e_mr));
    check("mem_write", 32'(bus8.mem_write_o), 32'(e_mw));
    check("mem_to_reg", 32'(bus8.mem_to_reg_o), 32'(e_m2r));
    check("branch_taken", 32'(bus8.branch_taken_o), 32'(e_bt));
    check("exc", 32'(bus8.exc_o), 32'(e_exc));
    check("epc", bus8.epc_o, e_epc);
    check("ovf_cnt8", 32'(bus8.ovf_cnt_o), 32'(sat(e_traps, 255)));
    check("ovf_cnt2", 32'(bus2.ovf_cnt_o), 32'(sat(e_traps, 3)));
    check("exc2", 32'(bus2.exc_o), 32'(e_exc));
    // Payload is only meaningful for a real instruction.
    if (e_valid) begin
      check("pc", bus8.pc_o, e_pc);
      check("alu_result", bus8.alu_result_o, e_alu);
      check("rt_data", bus8.rt_data_o, e_rt);
      check("write_reg", 32'(bus8.write_reg_o), 32'(e_wr));
      check("zero", 32'(bus8.zero_o), 32'(e_zero));
      check("cout", 32'(bus8.cout_o), 32'(e_cout));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    {stall, flush, valid, zero, ovf, cout, rw, mr, mw, m2r, br, trap_en} = '0;
    pc = '0; alu = '0; rt = '0; wr = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    model_reset();
    #12;
    check_all();
    check("reset_cnt", 32'(bus8.ovf_cnt_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: plain add
    valid = 1; alu = 32'h5; wr = 5'd8; rw = 1; pc = 32'h3C;
    step();
    check("t1_alu", bus8.alu_result_o, 32'h5);
    check("t1_rw", 32'(bus8.reg_write_o), 32'd1);

    // 2: trapping overflow
    pc = 32'h40; ovf = 1; trap_en = 1; alu = 32'h8000_0000;
    step();
    check("t2_exc", 32'(bus8.exc_o), 32'd1);
    check("t2_rw", 32'(bus8.reg_write_o), 32'd0);
    check("t2_epc", bus8.epc_o, 32'h40);
    check("t2_cnt", 32'(bus8.ovf_cnt_o), 32'd1);

    // 3: three stall cycles with changing inputs, then flush during stall
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h100 + 32'(i); alu = $urandom; ovf = 1; trap_en = 1;
      step();
    end
    check("t3_exc", 32'(bus8.exc_o), 32'd0);
    check("t3_epc", bus8.epc_o, 32'h40);
    flush = 1;
    step();
    check("t3_flush_valid", 32'(bus8.valid_o), 32'd0);
    idle_inputs();

    // 4: branch taken only for a valid instruction
    br = 1; zero = 1; valid = 1;
    step();
    check("t4_bt", 32'(bus8.branch_taken_o), 32'd1);
    valid = 0;
    step();
    check("t4_bt_inv", 32'(bus8.branch_taken_o), 32'd0);
    idle_inputs();

    // 5: $zero write suppressed; store
    valid = 1; wr = 5'd0; rw = 1;
    step();
    check("t5_rw0", 32'(bus8.reg_write_o), 32'd0);
    rw = 0; mw = 1; rt = 32'hDEADBEEF; wr = 5'd3;
    step();
    check("t5_mw", 32'(bus8.mem_write_o), 32'd1);
    check("t5_rt", bus8.rt_data_o, 32'hDEADBEEF);
    idle_inputs();

    // Overflow on a non-trapping op passes through; flush beats a trap
    valid = 1; ovf = 1; rw = 1; wr = 5'd9;
    step();
    trap_en = 1; flush = 1; pc = 32'h77;
    step();
    idle_inputs();

    // 6: five traps saturate the 2-bit counter
    valid = 1; ovf = 1; trap_en = 1;
    for (int i = 0; i < 5; i++) begin
      pc = 32'h200 + 32'(4 * i);
      step();
    end
    check("t6_cnt2", 32'(bus2.ovf_cnt_o), 32'd3);
    // Async reset in the middle of a cycle, with a trap just loaded
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    check("t6_rst_exc", 32'(bus8.exc_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      stall   = ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      valid   = ($urandom_range(0, 3) != 0);
      pc      = $urandom; alu = $urandom; rt = $urandom;
      wr      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      {zero, cout, rw, mr, mw, m2r, br} = 7'($urandom);
      ovf     = ($urandom_range(0, 2) == 0);
      trap_en = $urandom_range(0, 1) == 1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
